// File: rtl/aes_iter_core.sv
// =====================================================================
// aes_iter_core -- iterative AES-128/AES-256 encryptor, one round per clock
// Revision: 1.0
// =====================================================================
`default_nettype none

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

   // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
   always_comb begin
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      inv  = gf_mul(gf_mul(x240, x12), x2);
      y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_iter_core #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        din,
   input  logic [KEY_BITS-1:0] key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        dout
);
   localparam int         NR     = (KEY_BITS == 256) ? 14 : 10;
   localparam logic [3:0] NR_CNT = 4'(NR);

   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   state_t              fsm_q, fsm_d;
   logic [127:0]        st_q, st_d;
   logic [KEY_BITS-1:0] key_q, key_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                rdy_en_q, rdy_en_d;

   logic [7:0]          sub_b   [16];
   logic [7:0]          shift_b [16];
   logic [7:0]          mix_b   [16];
   logic [127:0]        round_out;
   logic [127:0]        rk_cur;
   logic [KEY_BITS-1:0] key_next;
   logic [7:0]          rcon_next;
   logic [31:0]         ks_sub, ks_rot;
   logic                accept, last_round;

   for (genvar i = 0; i < 16; i++) begin : g_sbox_data
      aes_sbox u_sbox (.a(st_q[127-8*i -: 8]), .y(sub_b[i]));
   end

   // The key schedule always substitutes the last word held in key_q.
   for (genvar i = 0; i < 4; i++) begin : g_sbox_key
      aes_sbox u_sbox (.a(key_q[31-8*i -: 8]), .y(ks_sub[31-8*i -: 8]));
   end

   assign ks_rot = {ks_sub[23:0], ks_sub[31:24]};

   if (KEY_BITS == 128) begin : g_k128
      // key_q holds K(r-1); Kr is expanded combinationally during round r.
      logic [31:0] t, n0, n1, n2, n3;
      assign t         = ks_rot ^ {rcon_q, 24'h000000};
      assign n0        = key_q[127:96] ^ t;
      assign n1        = key_q[95:64]  ^ n0;
      assign n2        = key_q[63:32]  ^ n1;
      assign n3        = key_q[31:0]   ^ n2;
      assign rk_cur    = {n0, n1, n2, n3};
      assign key_next  = rk_cur;
      assign rcon_next = xtime(rcon_q);
   end else if (KEY_BITS == 256) begin : g_k256
      // key_q holds {K(r-1), Kr}; even-numbered next keys take RotWord and Rcon.
      logic        even_next;
      logic [31:0] t, n0, n1, n2, n3;
      assign even_next = cnt_q[0];
      assign t         = even_next ? (ks_rot ^ {rcon_q, 24'h000000}) : ks_sub;
      assign n0        = key_q[255:224] ^ t;
      assign n1        = key_q[223:192] ^ n0;
      assign n2        = key_q[191:160] ^ n1;
      assign n3        = key_q[159:128] ^ n2;
      assign rk_cur    = key_q[127:0];
      assign key_next  = {key_q[127:0], n0, n1, n2, n3};
      assign rcon_next = even_next ? xtime(rcon_q) : rcon_q;
   end else begin : g_bad_key
      $error("aes_iter_core: KEY_BITS must be 128 or 256");
   end

   assign last_round = (cnt_q == NR_CNT);

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         shift_b[i] = 8'h00;
         mix_b[i]   = 8'h00;
      end
      round_out = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_b[4*c+r] = sub_b[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         if (last_round) begin
            for (int r = 0; r < 4; r++) mix_b[4*c+r] = shift_b[4*c+r];
         end else begin
            mix_b[4*c+0] = xtime(shift_b[4*c+0]) ^ xtime(shift_b[4*c+1]) ^ shift_b[4*c+1]
                         ^ shift_b[4*c+2] ^ shift_b[4*c+3];
            mix_b[4*c+1] = shift_b[4*c+0] ^ xtime(shift_b[4*c+1]) ^ xtime(shift_b[4*c+2])
                         ^ shift_b[4*c+2] ^ shift_b[4*c+3];
            mix_b[4*c+2] = shift_b[4*c+0] ^ shift_b[4*c+1] ^ xtime(shift_b[4*c+2])
                         ^ xtime(shift_b[4*c+3]) ^ shift_b[4*c+3];
            mix_b[4*c+3] = xtime(shift_b[4*c+0]) ^ shift_b[4*c+0] ^ shift_b[4*c+1]
                         ^ shift_b[4*c+2] ^ xtime(shift_b[4*c+3]);
         end
      end
      for (int i = 0; i < 16; i++) round_out[127-8*i -: 8] = mix_b[i];
      round_out = round_out ^ rk_cur;
   end

   always_comb begin
      case (fsm_q)
         IDLE:    in_ready = rdy_en_q;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      fsm_d       = fsm_q;
      st_d        = st_q;
      key_d       = key_q;
      rcon_d      = rcon_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      rdy_en_d    = 1'b1;
      case (fsm_q)
         ROUND: begin
            st_d   = round_out;
            key_d  = key_next;
            rcon_d = rcon_next;
            cnt_d  = cnt_q + 4'd1;
            if (last_round) begin
               fsm_d       = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d       = IDLE;
               out_valid_d = 1'b0;
               cnt_d       = 4'd0;
            end
         end
         default: ;
      endcase
      // An accept in DONE overrides the return to IDLE (back-to-back blocks).
      if (accept) begin
         fsm_d       = ROUND;
         st_d        = din ^ key[KEY_BITS-1 -: 128];
         key_d       = key;
         rcon_d      = 8'h01;
         cnt_d       = 4'd1;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         st_q        <= 128'h0;
         key_q       <= '0;
         rcon_q      <= 8'h01;
         cnt_q       <= 4'd0;
         out_valid_q <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         st_q        <= st_d;
         key_q       <= key_d;
         rcon_q      <= rcon_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         rdy_en_q    <= rdy_en_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = st_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_iter_core.sv
// =====================================================================
// tb_aes_iter_core -- self-checking bench for aes_iter_core (128 and 256)
// Revision: 1.0
// =====================================================================
`default_nettype none

module tb_aes_iter_core;
   localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] KEY256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   typedef struct {
      logic [127:0] expv;
      int           acc;
   } sb_t;

   logic         clk, rst_n;
   logic         iv1, ir1, ov1, or1;
   logic [127:0] din1, key1, dout1;
   logic         iv2, ir2, ov2, or2;
   logic [127:0] din2, dout2;
   logic [255:0] key2;

   logic [127:0] exp_cur;
   sb_t          sb [$];
   sb_t          e;
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           xfers = 0;
   int           last_rise = -100;
   logic         ov_prev = 1'b0;

   aes_iter_core #(.KEY_BITS(128)) u_dut128 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .din(din1), .key(key1),
      .out_valid(ov1), .out_ready(or1), .dout(dout1));

   aes_iter_core #(.KEY_BITS(256)) u_dut256 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .din(din2), .key(key2),
      .out_valid(ov2), .out_ready(or2), .dout(dout2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Scoreboard for the 128-bit core: push on accept, pop on each new result.
   always @(negedge clk) begin
      if (iv1 && ir1) sb.push_back('{expv: exp_cur, acc: cyc + 1});
      if (ov1 && !ov_prev) begin
         check("out_expected", 128'(sb.size() != 0), 128'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("dout", dout1, e.expv);
            check("latency", 128'(cyc - e.acc), 128'd10);
            if (e.acc == last_rise + 1) check("b2b_gap", 128'(cyc - last_rise), 128'd11);
         end
         last_rise = cyc;
      end
      if (ov1 && or1) xfers++;
      ov_prev = ov1;
   end

   task automatic send1(input logic [127:0] d, input logic [127:0] k, input logic [127:0] ev);
      int n;
      @(posedge clk); #1;
      iv1 = 1'b1; din1 = d; key1 = k; exp_cur = ev;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (ir1) break;
         n++;
      end
      check("accept_ready", 128'(ir1), 128'd1);
      @(posedge clk); #1;
      iv1 = 1'b0; din1 = {4{$urandom}}; key1 = {4{$urandom}};
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 128'(sb.size()), 128'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] pts [4];
      logic [127:0] keys [4];
      logic [127:0] cts [4];
      int n, acc2, x0, idx, start;
      pts  = '{PT1, PT2, PT1, PT2};
      keys = '{KEY1, KEY2, KEY1, KEY2};
      cts  = '{CT1, CT2, CT1, CT2};

      rst_n = 1'b0; iv1 = 1'b0; or1 = 1'b1; din1 = '0; key1 = '0; exp_cur = '0;
      iv2 = 1'b0; or2 = 1'b1; din2 = '0; key2 = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 128'(ir1), 128'd0);
      check("rst_out_valid", 128'(ov1), 128'd0);
      check("rst_dout", dout1, 128'd0);
      check("rst_in_ready_256", 128'(ir2), 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 128'(ir1), 128'd1);
      check("post_rst_ready_256", 128'(ir2), 128'd1);

      // AES-256 known answer with latency
      @(posedge clk); #1;
      iv2 = 1'b1; din2 = PT1; key2 = KEY256;
      @(negedge clk);
      check("k256_ready", 128'(ir2), 128'd1);
      acc2 = cyc + 1;
      @(posedge clk); #1;
      iv2 = 1'b0; din2 = {4{$urandom}}; key2 = {8{$urandom}};
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ov2 && n < 40);
      check("k256_valid", 128'(ov2), 128'd1);
      check("k256_latency", 128'(cyc - acc2), 128'd14);
      check("k256_dout", dout2, CT256);
      @(negedge clk);
      check("k256_valid_drop", 128'(ov2), 128'd0);
      check("k256_ready_again", 128'(ir2), 128'd1);

      // AES-128 known answers
      send1(PT1, KEY1, CT1);
      drain();
      send1(PT2, KEY2, CT2);
      drain();

      // Backpressure: result held for 20 cycles, then exactly one transfer
      or1 = 1'b0;
      send1(PT1, KEY1, CT1);
      n = 0;
      while (!ov1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid", 128'(ov1), 128'd1);
      repeat (20) begin
         @(negedge clk);
         check("bp_hold_valid", 128'(ov1), 128'd1);
         check("bp_hold_dout", dout1, CT1);
         check("bp_in_ready", 128'(ir1), 128'd0);
      end
      @(posedge clk); #1;
      x0 = xfers;
      or1 = 1'b1;
      repeat (4) @(negedge clk);
      check("bp_one_xfer", 128'(xfers - x0), 128'd1);
      check("bp_valid_low", 128'(ov1), 128'd0);

      // Back-to-back with in_valid held high and din/key scrambled while busy
      @(posedge clk); #1;
      start = cyc;
      idx = 0;
      iv1 = 1'b1;
      n = 0;
      while (idx < 4 && n < 200) begin
         if (ir1) begin
            din1 = pts[idx]; key1 = keys[idx]; exp_cur = cts[idx];
            idx++;
         end else begin
            din1 = {4{$urandom}}; key1 = {4{$urandom}};
         end
         @(posedge clk); #1;
         n++;
      end
      iv1 = 1'b0;
      check("b2b_span", 128'(cyc - start), 128'd34);
      drain();

      // Reset during round 5 discards the block
      send1(PT2, KEY2, CT2);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 128'(ov1), 128'd0);
      check("mid_rst_dout", dout1, 128'd0);
      check("mid_rst_ready", 128'(ir1), 128'd0);
      check("mid_rst_dout_256", dout2, 128'd0);
      sb.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      send1(PT1, KEY1, CT1);
      drain();

      repeat (3) @(negedge clk);
      check("sb_empty", 128'(sb.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
